spiflash_emu: RTL and testbench
===============================

# spiflash_emu

Synthesizable, emulator-friendly SPI/QSPI NOR flash model that replaces the transactor-based flash model in PicoSoC emulation benches. It runs on the emulation clock, oversamples the SoC's `flash_clk`/`flash_csb`/`io` lines, and serves read commands from an internal byte RAM preloaded through a backdoor port. Compared with the previous model it is parametrised in memory depth and dummy cycles, and adds dual/quad output, quad-I/O reads and continuous-read (XIP) mode.

## Interface
Parameters:
- `MEM_AW`, 16: byte-address width of internal RAM; depth = 2^MEM_AW bytes.
- `DUMMY_FAST`, 8: dummy clocks for 0x0B/0x3B/0x6B.
- `DUMMY_QIO`, 4: dummy clocks for 0xEB, after the mode byte.
- `QUAD_EN`, 1: 0 = 0x6B/0xEB treated as unknown commands.

Ports:
- `clk` in 1: emulation clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flash_csb` in 1: chip select, active low.
- `flash_clk` in 1: SPI clock, mode 0; each phase is ≥2 `clk` cycles.
- `io_in` in 4: sampled `{io3,io2,io1,io0}`.
- `io_out` out 4: driven data.
- `io_oe` out 4: per-bit output enable.
- `bd_we` in 1: backdoor write strobe.
- `bd_addr` in MEM_AW: backdoor byte address.
- `bd_wdata` in 8: backdoor byte.
- `busy` out 1: high while `flash_csb` is low and state ≠ IDLE.

## Operation
- Edge detect: registered `flash_clk`. Rise = sample inputs; fall = shift outputs.
- States:
  - IDLE: exits on `flash_csb` low. Goes to ADDR (quad) if `xip` is set, else CMD.
  - CMD: 8 single bits on `io0`, MSB first. Decodes to ADDR (0x03/0x0B/0x3B/0x6B/0xEB) or IGNORE (all other opcodes, including 0xAB/0xFF).
  - ADDR: 24 bits, on `io0` (6 clocks quad on io3..0 for 0xEB). Only the low MEM_AW bits are used, so the address wraps modulo the depth.
    - 0x03 goes to DATA.
    - 0x0B/0x3B/0x6B go to DUMMY.
    - 0xEB goes to MODE.
  - MODE: 2 quad clocks. `xip` is set when mode[5:4]==2'b10 and cleared otherwise. Then goes to DUMMY.
  - DUMMY: counts DUMMY_FAST or DUMMY_QIO rising edges, then goes to DATA.
  - DATA: emits bytes MSB first, one per 8/4/2 falling edges for single/dual/quad. The address increments per byte and wraps from 2^MEM_AW−1 to 0.
  - IGNORE: holds until `flash_csb` goes high.
- Lane mapping:
  - Single: `io1`, with oe=4'b0010.
  - Dual: `{io1,io0}=bits[7:6]` first, with oe=4'b0011.
  - Quad: `io3..io0=bits[7:4]` first, with oe=4'b1111.
- Memory: synchronous RAM with 1-cycle read latency. The next byte is fetched when the address completes and again at each byte start. The ≥2-clk phase rule guarantees the data is ready.
- Backdoor writes are accepted in any state. A write to the byte currently being shifted does not affect that byte.
- `flash_csb` high in any state: go to IDLE and force `io_oe` to 0 on the next `clk`. `xip` is retained.

## Timing
- Reset values: `io_out`=0, `io_oe`=0, `busy`=0, state=IDLE, `xip`=0, counters=0. RAM contents are undefined.
- Inputs are sampled in the `clk` cycle in which the `flash_clk` rise is detected.
- Outputs update 1 `clk` after the `flash_clk` fall is detected.
- First data bits are driven on the first `flash_clk` fall after the last ADDR or DUMMY rising edge. For 0x03 this is the fall immediately after address bit 0.
- `io_oe` goes high together with the first data bits. It drops 1 `clk` after `flash_csb` rises.
- Reset asserted mid-transaction: all outputs clear asynchronously. After release the model waits in IDLE; a transaction still in progress is not resumed.

## Structure
- Package `spiflash_pkg`: opcode constants (`CMD_READ`=0x03, `CMD_FAST`=0x0B, `CMD_DOR`=0x3B, `CMD_QOR`=0x6B, `CMD_QIOR`=0xEB), state enum, lane-mode enum (SINGLE/DUAL/QUAD).
- Sub-module `spiflash_emu_mem`: single-clock byte RAM with one write port (backdoor) and one registered read port.
- Top level contains the edge detector, FSM, bit/dummy counters, shift register and address counter.

## Test plan
- Backdoor load [0x0100]=0xA5, [0x0101]=0x3C. Send 0x03 + 0x000100 and 16 clocks → `io1` carries 0xA5 then 0x3C, oe=4'b0010.
- MEM_AW=16, [0xFFFF]=0x11, [0x0000]=0x22. Send 0x0B + 0x00FFFF, 8 dummy clocks, 16 data clocks → 0x11 then 0x22 (wrap).
- Send 0x6B + 0x000100, 8 dummy clocks, 4 data clocks → io3..0 = 0xA, 0x5, 0x3, 0xC, oe=4'b1111.
- Send 0xEB + quad address 0x000100 + mode 0xA0 + 4 dummy clocks and read 1 byte. Raise csb, then lower it and send quad address 0x000101 with no command → 0x3C returned. Repeat with mode 0x00 → `xip` cleared.
- Raise `flash_csb` after 10 address bits → IDLE, `busy`=0, oe=0 within 1 clk. The next 0x03 transaction reads correctly.
- Unknown opcode 0x9F → oe stays 0 until csb is high. Assert `rst` mid-DATA → oe=0 and `io_out`=0 immediately.

Source files
------------

// File: rtl/spiflash_pkg.sv
// Shared opcodes, FSM states and output-lane helpers for the SPI/QSPI flash emulator.
package spiflash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_FAST = 8'h0B;
  localparam logic [7:0] CMD_DOR  = 8'h3B;
  localparam logic [7:0] CMD_QOR  = 8'h6B;
  localparam logic [7:0] CMD_QIOR = 8'hEB;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    MODE,
    DUMMY,
    DATA,
    IGNORE
  } state_e;

  typedef enum logic [1:0] {
    SINGLE,
    DUAL,
    QUAD
  } lane_e;

  function automatic logic [3:0] lane_oe(input lane_e lane);
    case (lane)
      SINGLE:  return 4'b0010;
      DUAL:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Places the leading bits of b onto the io pins for the given lane mode.
  function automatic logic [3:0] lane_bits(input lane_e lane, input logic [7:0] b);
    case (lane)
      SINGLE:  return {2'b00, b[7], 1'b0};
      DUAL:    return {2'b00, b[7:6]};
      default: return b[7:4];
    endcase
  endfunction

  function automatic logic [7:0] lane_shift(input lane_e lane, input logic [7:0] b);
    case (lane)
      SINGLE:  return b << 1;
      DUAL:    return b << 2;
      default: return b << 4;
    endcase
  endfunction

  // Index of the last falling edge within one byte.
  function automatic logic [7:0] lane_last(input lane_e lane);
    case (lane)
      SINGLE:  return 8'd7;
      DUAL:    return 8'd3;
      default: return 8'd1;
    endcase
  endfunction

endpackage

// File: rtl/spiflash_emu_mem.sv
// Byte RAM: one backdoor write port and one registered read port (1-cycle latency).
module spiflash_emu_mem #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] rdata_q;

  // NOTE: the array and its read register are deliberately left without reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spiflash_emu.sv
// SPI/QSPI NOR flash emulator: oversamples flash_clk on clk and serves reads from a backdoor-loaded RAM.
module spiflash_emu
  import spiflash_pkg::*;
#(
  parameter int MEM_AW     = 16,
  parameter int DUMMY_FAST = 8,
  parameter int DUMMY_QIO  = 4,
  parameter int QUAD_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flash_csb,
  input  logic              flash_clk,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out,
  output logic [3:0]        io_oe,
  input  logic              bd_we,
  input  logic [MEM_AW-1:0] bd_addr,
  input  logic [7:0]        bd_wdata,
  output logic              busy
);

  localparam logic [7:0] DUMMY_FAST_N = 8'(DUMMY_FAST);
  localparam logic [7:0] DUMMY_QIO_N  = 8'(DUMMY_QIO);

  logic              fclk_q;
  state_e            state_q, state_d;
  lane_e             lane_q, lane_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        mode_q, mode_d;
  logic [7:0]        shift_q, shift_d;
  logic              xip_q, xip_d;
  logic [3:0]        io_out_q, io_out_d;
  logic [3:0]        io_oe_q, io_oe_d;

  logic              mem_re;
  logic [MEM_AW-1:0] mem_raddr;
  logic [7:0]        mem_rdata;

  logic              fclk_rise, fclk_fall;
  logic              addr_quad, addr_done;
  logic [MEM_AW-1:0] addr_in;
  logic [7:0]        dummy_n;
  logic [7:0]        data_cur;

  assign fclk_rise = flash_clk & ~fclk_q;
  assign fclk_fall = ~flash_clk & fclk_q;

  // Shifting into an MEM_AW-wide register keeps only the low address bits, giving the modulo-depth wrap.
  assign addr_quad = (cmd_q == CMD_QIOR);
  assign addr_in   = addr_quad ? MEM_AW'({addr_q, io_in}) : MEM_AW'({addr_q, io_in[0]});
  assign addr_done = addr_quad ? (cnt_q == 8'd5) : (cnt_q == 8'd23);
  assign dummy_n   = addr_quad ? DUMMY_QIO_N : DUMMY_FAST_N;

  // At a byte start the prefetched RAM word is used directly; later edges drain the shift register.
  assign data_cur  = (cnt_q == 8'd0) ? mem_rdata : shift_q;

  spiflash_emu_mem #(
    .AW (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .we    (bd_we),
    .waddr (bd_addr),
    .wdata (bd_wdata),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    shift_d   = shift_q;
    xip_d     = xip_q;
    io_out_d  = io_out_q;
    io_oe_d   = io_oe_q;
    mem_re    = 1'b0;
    mem_raddr = addr_q;

    if (flash_csb) begin
      state_d  = IDLE;
      cnt_d    = '0;
      io_out_d = '0;
      io_oe_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (xip_q) begin
            state_d = ADDR;
            cmd_d   = CMD_QIOR;
            lane_d  = QUAD;
          end else begin
            state_d = CMD;
          end
        end

        CMD: if (fclk_rise) begin
          cmd_d = {cmd_q[6:0], io_in[0]};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == 8'd7) begin
            cnt_d   = '0;
            state_d = IGNORE;
            case (cmd_d)
              CMD_READ, CMD_FAST: begin
                state_d = ADDR;
                lane_d  = SINGLE;
              end
              CMD_DOR: begin
                state_d = ADDR;
                lane_d  = DUAL;
              end
              CMD_QOR, CMD_QIOR: if (QUAD_EN != 0) begin
                state_d = ADDR;
                lane_d  = QUAD;
              end
              default: ;
            endcase
          end
        end

        ADDR: if (fclk_rise) begin
          addr_d = addr_in;
          cnt_d  = cnt_q + 8'd1;
          if (addr_done) begin
            mem_re    = 1'b1;
            mem_raddr = addr_in;
            addr_d    = addr_in + MEM_AW'(1);
            cnt_d     = '0;
            if (cmd_q == CMD_READ)      state_d = DATA;
            else if (addr_quad)         state_d = MODE;
            else if (dummy_n == 8'd0)   state_d = DATA;
            else                        state_d = DUMMY;
          end
        end

        MODE: if (fclk_rise) begin
          mode_d = io_in;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'd1) begin
            // Mode byte is {mode_q, io_in}; its bits [5:4] are mode_q[1:0].
            xip_d   = (mode_q[1:0] == 2'b10);
            cnt_d   = '0;
            state_d = (dummy_n == 8'd0) ? DATA : DUMMY;
          end
        end

        DUMMY: if (fclk_rise) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == dummy_n - 8'd1) begin
            cnt_d   = '0;
            state_d = DATA;
          end
        end

        DATA: if (fclk_fall) begin
          io_out_d = lane_bits(lane_q, data_cur);
          io_oe_d  = lane_oe(lane_q);
          shift_d  = lane_shift(lane_q, data_cur);
          if (cnt_q == 8'd0) begin
            mem_re = 1'b1;
            addr_d = addr_q + MEM_AW'(1);
          end
          cnt_d = (cnt_q == lane_last(lane_q)) ? 8'd0 : cnt_q + 8'd1;
        end

        IGNORE: ;

        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fclk_q   <= 1'b0;
      state_q  <= IDLE;
      lane_q   <= SINGLE;
      cnt_q    <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      mode_q   <= '0;
      shift_q  <= '0;
      xip_q    <= 1'b0;
      io_out_q <= '0;
      io_oe_q  <= '0;
    end else begin
      fclk_q   <= flash_clk;
      state_q  <= state_d;
      lane_q   <= lane_d;
      cnt_q    <= cnt_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      mode_q   <= mode_d;
      shift_q  <= shift_d;
      xip_q    <= xip_d;
      io_out_q <= io_out_d;
      io_oe_q  <= io_oe_d;
    end
  end

  assign io_out = io_out_q;
  assign io_oe  = io_oe_q;
  assign busy   = ~flash_csb && (state_q != IDLE);

endmodule

// File: tb/tb_spiflash_emu.sv
// Scoreboard bench for spiflash_emu: a bench-side SPI master drives reads, expected bytes come from a memory model.
module tb_spiflash_emu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flash_csb = 1'b1;
  logic        flash_clk = 1'b0;
  logic [3:0]  io_in = 4'h0;
  logic [3:0]  io_out, io_oe;
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0;
  logic [7:0]  bd_wdata = '0;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  model_mem [0:65535];
  logic [3:0]  smp, oe_smp, oe_acc;

  always #5 clk = ~clk;

  spiflash_emu #(
    .MEM_AW     (16),
    .DUMMY_FAST (8),
    .DUMMY_QIO  (4),
    .QUAD_EN    (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flash_csb (flash_csb),
    .flash_clk (flash_clk),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oe     (io_oe),
    .bd_we     (bd_we),
    .bd_addr   (bd_addr),
    .bd_wdata  (bd_wdata),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    @(negedge clk);
    bd_we = 1'b0;
    model_mem[a] = d;
  endtask

  // One SPI mode-0 clock: drive during the low phase, sample DUT outputs just before the rise.
  task automatic spi_cycle(input logic [3:0] drv);
    io_in = drv;
    wait_clk(4);
    smp = io_out;
    oe_smp = io_oe;
    flash_clk = 1'b1;
    wait_clk(4);
    flash_clk = 1'b0;
  endtask

  task automatic cs_on;
    flash_csb = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_off;
    flash_csb = 1'b1;
    wait_clk(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_cycle({3'b000, b[i]});
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) spi_cycle({3'b000, a[i]});
  endtask

  task automatic send_quad(input logic [23:0] v, input int nib);
    for (int i = nib - 1; i >= 0; i--) spi_cycle(v[i*4 +: 4]);
  endtask

  task automatic dummy(input int n);
    repeat (n) spi_cycle(4'h0);
  endtask

  // Collects one byte at bpc bits per clock and compares it with the scoreboard head.
  task automatic read_byte(input int bpc, input logic [3:0] exp_oe, input string tag);
    logic [7:0] b;
    logic [7:0] e;
    b = '0;
    for (int i = 0; i < 8 / bpc; i++) begin
      spi_cycle(4'h0);
      case (bpc)
        1:       b = {b[6:0], smp[1]};
        2:       b = {b[5:0], smp[1:0]};
        default: b = {b[3:0], smp};
      endcase
    end
    check({tag, "_oe"}, 32'(oe_smp), 32'(exp_oe));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    check(tag, 32'(b), 32'(e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wait_clk(3);
    check("rst_oe", 32'(io_oe), 0);
    check("rst_out", 32'(io_out), 0);
    check("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    wait_clk(2);

    bd_write(16'h0100, 8'hA5);
    bd_write(16'h0101, 8'h3C);
    bd_write(16'hFFFF, 8'h11);
    bd_write(16'h0000, 8'h22);

    // Plain read, then csb mid-data must drop oe within one clk.
    exp_q.push_back(model_mem[16'h0100]);
    exp_q.push_back(model_mem[16'h0101]);
    cs_on;
    check("busy_cmd", 32'(busy), 1);
    send_byte(8'h03);
    send_addr(24'h000100);
    check("oe_addr", 32'(oe_smp), 0);
    read_byte(1, 4'b0010, "rd03_a");
    read_byte(1, 4'b0010, "rd03_b");
    flash_csb = 1'b1;
    @(negedge clk);
    check("csb_oe", 32'(io_oe), 0);
    check("csb_busy", 32'(busy), 0);
    wait_clk(3);

    // Fast read across the top of memory.
    exp_q.push_back(model_mem[16'hFFFF]);
    exp_q.push_back(model_mem[16'h0000]);
    cs_on;
    send_byte(8'h0B);
    send_addr(24'h00FFFF);
    dummy(8);
    read_byte(1, 4'b0010, "fast_ffff");
    read_byte(1, 4'b0010, "fast_wrap");
    cs_off;

    exp_q.push_back(model_mem[16'h0100]);
    cs_on;
    send_byte(8'h3B);
    send_addr(24'h000100);
    dummy(8);
    read_byte(2, 4'b0011, "dor");
    cs_off;

    exp_q.push_back(model_mem[16'h0100]);
    exp_q.push_back(model_mem[16'h0101]);
    cs_on;
    send_byte(8'h6B);
    send_addr(24'h000100);
    dummy(8);
    read_byte(4, 4'b1111, "qor_a");
    read_byte(4, 4'b1111, "qor_b");
    cs_off;

    // Quad I/O read entering continuous mode, then a command-less access that exits it.
    exp_q.push_back(model_mem[16'h0100]);
    cs_on;
    send_byte(8'hEB);
    send_quad(24'h000100, 6);
    send_quad(24'h0000A0, 2);
    dummy(4);
    read_byte(4, 4'b1111, "qior");
    cs_off;

    exp_q.push_back(model_mem[16'h0101]);
    cs_on;
    send_quad(24'h000101, 6);
    send_quad(24'h000000, 2);
    dummy(4);
    read_byte(4, 4'b1111, "xip");
    cs_off;

    exp_q.push_back(model_mem[16'h0100]);
    cs_on;
    send_byte(8'h03);
    send_addr(24'h000100);
    read_byte(1, 4'b0010, "xip_off");
    cs_off;

    // Abort during the address phase, then a clean transaction.
    cs_on;
    send_byte(8'h03);
    repeat (10) spi_cycle(4'h0);
    flash_csb = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_oe", 32'(io_oe), 0);
    wait_clk(3);
    exp_q.push_back(model_mem[16'h0101]);
    cs_on;
    send_byte(8'h03);
    send_addr(24'h000101);
    read_byte(1, 4'b0010, "post_abort");
    cs_off;

    // Unknown opcode: never drives.
    cs_on;
    send_byte(8'h9F);
    oe_acc = '0;
    repeat (16) begin
      spi_cycle(4'h0);
      oe_acc = oe_acc | oe_smp;
    end
    check("ign_oe", 32'(oe_acc), 0);
    check("ign_busy", 32'(busy), 1);
    cs_off;
    check("ign_idle", 32'(busy), 0);

    // Asynchronous reset while a data bit is on io1.
    cs_on;
    send_byte(8'h03);
    send_addr(24'h000100);
    spi_cycle(4'h0);
    check("pre_rst_bit", 32'(smp), 32'(4'b0010));
    check("pre_rst_out", 32'(io_out), 32'(4'b0010));
    #2 rst = 1'b1;
    #1;
    check("rst_async_oe", 32'(io_oe), 0);
    check("rst_async_out", 32'(io_out), 0);
    flash_csb = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(4);
    check("rst_busy2", 32'(busy), 0);
    exp_q.push_back(model_mem[16'h0100]);
    cs_on;
    send_byte(8'h03);
    send_addr(24'h000100);
    read_byte(1, 4'b0010, "post_rst");
    cs_off;

    check("sb_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
